// File: rtl/y_coeff_serializer.sv
// Ping-pong capture of a 64-coefficient y_dct block and one-per-beat valid/ready streaming.
// Define Y_SER_ZIGZAG_EN for JPEG zigzag output order; otherwise raster order is used.
module y_coeff_serializer (
    input  logic         clk,
    input  logic         rst,
    input  logic         output_enable,
    input  logic [703:0] coeff_in,
    output logic [10:0]  coeff_out,
    output logic         coeff_valid,
    input  logic         coeff_ready,
    output logic [5:0]   coeff_index,
    output logic         coeff_last,
    output logic         block_dropped
);

    logic [10:0] coeff_z [64];
    logic [10:0] bank_mem [2][64];
    logic [1:0]  full_reg;
    logic        wb_reg;
    logic        rb_reg;
    logic [5:0]  rcnt_reg;
    logic        dropped_reg;
    logic [5:0]  rd_addr;
    logic        capture;
    logic        transfer;

    genvar gi;
    generate
        for (gi = 0; gi < 64; gi++) begin : g_unpack
            assign coeff_z[gi] = coeff_in[gi*11 +: 11];
        end
    endgenerate

`ifdef Y_SER_ZIGZAG_EN
    localparam logic [5:0] ZZ_ORDER [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };
    assign rd_addr = ZZ_ORDER[rcnt_reg];
`else
    assign rd_addr = rcnt_reg;
`endif

    // Both decisions use pre-edge flags, so a bank freed this edge is still seen as full.
    assign capture  = output_enable && !full_reg[wb_reg];
    assign transfer = full_reg[rb_reg] && coeff_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_reg    <= 2'b00;
            wb_reg      <= 1'b0;
            rb_reg      <= 1'b0;
            rcnt_reg    <= 6'd0;
            dropped_reg <= 1'b0;
        end else begin
            if (output_enable && full_reg[wb_reg]) begin
                dropped_reg <= 1'b1;
            end
            if (capture) begin
                full_reg[wb_reg] <= 1'b1;
                wb_reg           <= ~wb_reg;
            end
            if (transfer) begin
                rcnt_reg <= rcnt_reg + 6'd1;
                if (rcnt_reg == 6'd63) begin
                    full_reg[rb_reg] <= 1'b0;
                    rb_reg           <= ~rb_reg;
                end
            end
        end
    end

    // Storage is never reset; a bank is only written while it is empty.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int i = 0; i < 64; i++) begin
                bank_mem[wb_reg][i] <= coeff_z[i];
            end
        end
    end

    assign coeff_valid   = full_reg[rb_reg];
    assign coeff_out     = coeff_valid ? bank_mem[rb_reg][rd_addr] : 11'd0;
    assign coeff_index   = rcnt_reg;
    assign coeff_last    = coeff_valid && (rcnt_reg == 6'd63);
    assign block_dropped = dropped_reg;

endmodule

// File: tb/tb_y_coeff_serializer.sv
// Self-checking bench for y_coeff_serializer: directed table, hand sequences and
// randomized traffic compared against a block-queue reference model.
module tb_y_coeff_serializer;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         output_enable = 1'b0;
    logic [703:0] coeff_in = '0;
    logic [10:0]  coeff_out;
    logic         coeff_valid;
    logic         coeff_ready = 1'b0;
    logic [5:0]   coeff_index;
    logic         coeff_last;
    logic         block_dropped;

    y_coeff_serializer dut (
        .clk           (clk),
        .rst           (rst),
        .output_enable (output_enable),
        .coeff_in      (coeff_in),
        .coeff_out     (coeff_out),
        .coeff_valid   (coeff_valid),
        .coeff_ready   (coeff_ready),
        .coeff_index   (coeff_index),
        .coeff_last    (coeff_last),
        .block_dropped (block_dropped)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int ord [64];
    int blk_count = 0;

    // Reference model: FIFO of at most two pending blocks, each held in output order.
    logic [703:0] m_q [$];
    int           m_pos = 0;
    logic         m_drop = 1'b0;

    typedef struct {
        logic        oe;
        logic        rdy;
        logic [10:0] fillv;
        logic        ev;
        logic [5:0]  ei;
        logic        el;
        logic        ed;
        logic [10:0] eo;
    } vec_t;
    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [703:0] fill(input logic [10:0] v);
        logic [703:0] r;
        for (int n = 0; n < 64; n++) r[n*11 +: 11] = v;
        return r;
    endfunction

    function automatic logic [703:0] reorder(input logic [703:0] d);
        logic [703:0] r;
        for (int n = 0; n < 64; n++) r[n*11 +: 11] = d[ord[n]*11 +: 11];
        return r;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_pos  = 0;
        m_drop = 1'b0;
    endtask

    task automatic model_step(input logic oe, input logic [703:0] d, input logic rdy);
        int   sz;
        logic xfer;
        logic cap;
        sz   = m_q.size();
        xfer = (sz > 0) && rdy;
        cap  = oe && (sz < 2);
        if (oe && !cap) begin
            m_drop = 1'b1;
            $display("block dropped at t=%0t", $time);
        end
        if (xfer) begin
            if (m_pos == 63) begin
                m_pos = 0;
                void'(m_q.pop_front());
                blk_count++;
                $display("block %0d streamed out at t=%0t", blk_count, $time);
            end else begin
                m_pos++;
            end
        end
        if (cap) m_q.push_back(reorder(d));
    endtask

    task automatic check_model();
        logic [703:0] h;
        logic         ev;
        ev = (m_q.size() > 0);
        chk("valid", 32'(coeff_valid), 32'(ev));
        chk("index", 32'(coeff_index), 32'(m_pos));
        chk("last", 32'(coeff_last), 32'(ev && (m_pos == 63)));
        chk("dropped", 32'(block_dropped), 32'(m_drop));
        if (ev) begin
            h = m_q[0];
            chk("coeff_out", 32'(coeff_out), 32'(h[m_pos*11 +: 11]));
        end
    endtask

    // Drive at negedge, model at posedge, compare at the following negedge.
    task automatic cycle(input logic oe, input logic [703:0] d, input logic rdy);
        output_enable = oe;
        coeff_in      = d;
        coeff_ready   = rdy;
        @(posedge clk);
        model_step(oe, d, rdy);
        @(negedge clk);
        check_model();
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_out"}, 32'(coeff_out), 32'd0);
        chk({tag, "_valid"}, 32'(coeff_valid), 32'd0);
        chk({tag, "_index"}, 32'(coeff_index), 32'd0);
        chk({tag, "_last"}, 32'(coeff_last), 32'd0);
        chk({tag, "_dropped"}, 32'(block_dropped), 32'd0);
    endtask

    initial begin
        logic [703:0] raster;
        logic [703:0] rnd;
        int k;

        // Output order derived by walking anti-diagonals (zigzag) or rows (raster).
        k = 0;
`ifdef Y_SER_ZIGZAG_EN
        for (int s = 0; s < 15; s++) begin
            if (s % 2 == 0) begin
                for (int r = (s < 8 ? s : 7); r >= (s > 7 ? s - 7 : 0); r--) begin
                    ord[k] = r * 8 + (s - r);
                    k++;
                end
            end else begin
                for (int r = (s > 7 ? s - 7 : 0); r <= (s < 8 ? s : 7); r++) begin
                    ord[k] = r * 8 + (s - r);
                    k++;
                end
            end
        end
`else
        for (int n = 0; n < 64; n++) ord[n] = n;
`endif
        for (int n = 0; n < 64; n++) raster[n*11 +: 11] = 11'(n);

        //            oe    rdy   fill  ev    ei  el    ed    eo
        tbl[0] = '{1'b0, 1'b1, 11'd0, 1'b0, 6'd0, 1'b0, 1'b0, 11'd0};
        tbl[1] = '{1'b1, 1'b0, 11'd1, 1'b1, 6'd0, 1'b0, 1'b0, 11'd1};
        tbl[2] = '{1'b0, 1'b0, 11'd0, 1'b1, 6'd0, 1'b0, 1'b0, 11'd1};
        tbl[3] = '{1'b1, 1'b0, 11'd2, 1'b1, 6'd0, 1'b0, 1'b0, 11'd1};
        tbl[4] = '{1'b1, 1'b0, 11'd3, 1'b1, 6'd0, 1'b0, 1'b1, 11'd1};
        tbl[5] = '{1'b0, 1'b1, 11'd0, 1'b1, 6'd1, 1'b0, 1'b1, 11'd1};
        tbl[6] = '{1'b0, 1'b1, 11'd0, 1'b1, 6'd2, 1'b0, 1'b1, 11'd1};
        tbl[7] = '{1'b0, 1'b0, 11'd0, 1'b1, 6'd2, 1'b0, 1'b1, 11'd1};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check_zero_outputs("reset");
        rst = 1'b0;
        model_reset();

        // Directed table: capture latency, second bank, overflow drop, stall
        for (int i = 0; i < 8; i++) begin
            cycle(tbl[i].oe, fill(tbl[i].fillv), tbl[i].rdy);
            chk($sformatf("tbl%0d_valid", i), 32'(coeff_valid), 32'(tbl[i].ev));
            chk($sformatf("tbl%0d_index", i), 32'(coeff_index), 32'(tbl[i].ei));
            chk($sformatf("tbl%0d_last", i), 32'(coeff_last), 32'(tbl[i].el));
            chk($sformatf("tbl%0d_dropped", i), 32'(block_dropped), 32'(tbl[i].ed));
            if (tbl[i].ev) chk($sformatf("tbl%0d_out", i), 32'(coeff_out), 32'(tbl[i].eo));
        end
        // Overflow drain: 64 x 1 then 64 x 2, never 3
        for (int i = 0; i < 130; i++) cycle(1'b0, '0, 1'b1);
        chk("overflow_empty", 32'(coeff_valid), 32'd0);

        // Reset mid-stream after 20 transfers
        cycle(1'b1, fill(11'h155), 1'b1);
        for (int i = 0; i < 20; i++) cycle(1'b0, '0, 1'b1);
        #2 rst = 1'b1;
        #1 check_zero_outputs("async_rst");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        cycle(1'b1, fill(11'h2AA), 1'b1);
        chk("post_rst_index", 32'(coeff_index), 32'd0);
        chk("post_rst_out", 32'(coeff_out), 32'h2AA);
        for (int i = 0; i < 70; i++) cycle(1'b0, '0, 1'b1);

        // Single raster-pattern block, ready held high
        cycle(1'b1, raster, 1'b1);
        chk("first_coeff", 32'(coeff_out), 32'd0);
        for (int i = 0; i < 70; i++) cycle(1'b0, '0, 1'b1);

        // Backpressure: ready 1,0,0,1 repeating
        cycle(1'b1, raster, 1'b1);
        for (int i = 0; i < 200; i++) cycle(1'b0, '0, (i % 4 == 0) || (i % 4 == 3));
        chk("bp_done", 32'(coeff_valid), 32'd0);

        // Back-to-back blocks, pulses 3 cycles apart
        cycle(1'b1, fill(11'h005), 1'b1);
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b1);
        cycle(1'b1, fill(11'h7FB), 1'b1);
        for (int i = 0; i < 140; i++) cycle(1'b0, '0, 1'b1);
        chk("b2b_no_drop", 32'(block_dropped), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            for (int w = 0; w < 22; w++) rnd[w*32 +: 32] = $urandom;
            cycle(($urandom_range(0, 29) == 0), rnd, ($urandom_range(0, 3) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
